wash_cycle_ctrl: RTL and testbench

- Top-level cycle sequencer for the washing machine.
- Sits directly upstream of the phase counters (filling, washing, rinsing, spinning): drives their start, round-2 and soft-reset inputs, and consumes their done flags.
- Sequence per coin: IDLE -> FILL -> WASH -> RINSE -> (optional WASH/RINSE second pass) -> SPIN -> IDLE.
- Handles the double-wash option and the spin-phase pause.

---
 rtl/wash_cycle_ctrl_if.sv | 33 +++
 rtl/wash_cycle_ctrl.sv | 114 +++++++++++
 tb/tb_wash_cycle_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/wash_cycle_ctrl_if.sv
// rtl/wash_cycle_ctrl_if.sv - wash cycle sequencer bundle: operator inputs, counter done flags, counter controls
interface wash_cycle_ctrl_if;
    logic       coin_in;
    logic       double_wash;
    logic       timer_pause;
    logic       filling_done;
    logic       washing_done;
    logic       rinsing_done;
    logic       spinning_done;
    logic       start_filling;
    logic       start_washing;
    logic       start_rinsing;
    logic       start_spinning;
    logic       round2_washing;
    logic       round2_rinsing;
    logic       soft_rst;
    logic       wash_done;
    logic [2:0] state;

    modport master (
        output coin_in, double_wash, timer_pause,
        output filling_done, washing_done, rinsing_done, spinning_done,
        input  start_filling, start_washing, start_rinsing, start_spinning,
        input  round2_washing, round2_rinsing, soft_rst, wash_done, state
    );

    modport slave (
        input  coin_in, double_wash, timer_pause,
        input  filling_done, washing_done, rinsing_done, spinning_done,
        output start_filling, start_washing, start_rinsing, start_spinning,
        output round2_washing, round2_rinsing, soft_rst, wash_done, state
    );
endinterface

// File: rtl/wash_cycle_ctrl.sv
// rtl/wash_cycle_ctrl.sv - washing machine cycle sequencer driving the phase counters
module wash_cycle_ctrl #(
    parameter bit DOUBLE_WASH_EN = 1'b1,
    parameter bit PAUSE_EN       = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    wash_cycle_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WASH  = 3'd2,
        S_RINSE = 3'd3,
        S_SPIN  = 3'd4
    } state_t;

    state_t     r_state, w_state_nxt;
    logic       r_pass, w_pass_nxt;
    logic       r_dw_q, w_dw_nxt;
    logic       r_settle, w_settle_nxt;
    logic       r_soft_rst, w_soft_nxt;
    logic       r_wash_done, w_wash_done_nxt;
    logic [3:0] r_start, w_start_nxt;
    logic [1:0] r_round2, w_round2_nxt;
    logic       w_pause;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pass      <= 1'b0;
            r_dw_q      <= 1'b0;
            r_settle    <= 1'b0;
            r_soft_rst  <= 1'b0;
            r_wash_done <= 1'b0;
            r_start     <= 4'b0;
            r_round2    <= 2'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pass      <= w_pass_nxt;
            r_dw_q      <= w_dw_nxt;
            r_settle    <= w_settle_nxt;
            r_soft_rst  <= w_soft_nxt;
            r_wash_done <= w_wash_done_nxt;
            r_start     <= w_start_nxt;
            r_round2    <= w_round2_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pass_nxt      = r_pass;
        w_dw_nxt        = r_dw_q;
        w_wash_done_nxt = 1'b0;
        w_pause         = PAUSE_EN && bus.timer_pause && (r_state == S_SPIN);

        // r_settle masks done flags left over from the counter of the previous phase
        case (r_state)
            S_IDLE: begin
                if (bus.coin_in) begin
                    w_state_nxt = S_FILL;
                    w_dw_nxt    = bus.double_wash & DOUBLE_WASH_EN;
                    w_pass_nxt  = 1'b0;
                end
            end
            S_FILL:  if (!r_settle && bus.filling_done) w_state_nxt = S_WASH;
            S_WASH:  if (!r_settle && bus.washing_done) w_state_nxt = S_RINSE;
            S_RINSE: begin
                if (!r_settle && bus.rinsing_done) begin
                    if (r_dw_q && !r_pass) begin
                        w_state_nxt = S_WASH;
                        w_pass_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_SPIN;
                    end
                end
            end
            S_SPIN: begin
                if (!w_pause && !r_settle && bus.spinning_done) begin
                    w_state_nxt     = S_IDLE;
                    w_wash_done_nxt = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_settle_nxt = (w_state_nxt != r_state) && (w_state_nxt != S_IDLE);
        w_soft_nxt   = (w_state_nxt != S_IDLE) && !w_settle_nxt;

        w_start_nxt = 4'b0;
        if (!w_settle_nxt) begin
            case (w_state_nxt)
                S_FILL:  w_start_nxt[0] = 1'b1;
                S_WASH:  w_start_nxt[1] = 1'b1;
                S_RINSE: w_start_nxt[2] = 1'b1;
                S_SPIN:  w_start_nxt[3] = !w_pause;
                default: w_start_nxt    = 4'b0;
            endcase
        end

        w_round2_nxt = {(w_state_nxt == S_RINSE) && w_pass_nxt,
                        (w_state_nxt == S_WASH)  && w_pass_nxt};
    end

    assign bus.state          = r_state;
    assign bus.start_filling  = r_start[0];
    assign bus.start_washing  = r_start[1];
    assign bus.start_rinsing  = r_start[2];
    assign bus.start_spinning = r_start[3];
    assign bus.round2_washing = r_round2[0];
    assign bus.round2_rinsing = r_round2[1];
    assign bus.soft_rst       = r_soft_rst;
    assign bus.wash_done      = r_wash_done;
endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// tb/tb_wash_cycle_ctrl.sv - randomized bench for wash_cycle_ctrl against a phase/age reference model
module tb_wash_cycle_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic coin, dw, tp, fd, wd, rd, sd;

    wash_cycle_ctrl_if bus0 ();
    wash_cycle_ctrl_if bus1 ();

    wash_cycle_ctrl #(.DOUBLE_WASH_EN(1'b1), .PAUSE_EN(1'b1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    wash_cycle_ctrl #(.DOUBLE_WASH_EN(1'b0), .PAUSE_EN(1'b0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    assign bus0.coin_in = coin;       assign bus1.coin_in = coin;
    assign bus0.double_wash = dw;     assign bus1.double_wash = dw;
    assign bus0.timer_pause = tp;     assign bus1.timer_pause = tp;
    assign bus0.filling_done = fd;    assign bus1.filling_done = fd;
    assign bus0.washing_done = wd;    assign bus1.washing_done = wd;
    assign bus0.rinsing_done = rd;    assign bus1.rinsing_done = rd;
    assign bus0.spinning_done = sd;   assign bus1.spinning_done = sd;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Phase number plus cycles spent in it; age 0 is the settle cycle after entry.
    typedef struct {
        int phase;
        int age;
        bit pass;
        bit dwq;
    } mdl_t;
    mdl_t m [2];

    task automatic model_step(input int k, input bit dwen, input bit pen, output logic [10:0] exp);
        mdl_t s;
        int   nxt;
        bit   paused;
        bit   pulse;
        bit   st [1:4];
        s      = m[k];
        paused = 1'b0;
        pulse  = 1'b0;
        if (!rst_n) begin
            s.phase = 0; s.age = 0; s.pass = 1'b0; s.dwq = 1'b0;
            m[k] = s;
            exp  = '0;
        end else begin
            nxt = s.phase;
            case (s.phase)
                0: if (coin) begin nxt = 1; s.dwq = dw & dwen; s.pass = 1'b0; end
                1: if (s.age > 0 && fd) nxt = 2;
                2: if (s.age > 0 && wd) nxt = 3;
                3: if (s.age > 0 && rd) begin
                       if (s.dwq && !s.pass) begin nxt = 2; s.pass = 1'b1; end
                       else nxt = 4;
                   end
                4: begin
                       paused = pen && tp;
                       if (!paused && s.age > 0 && sd) begin nxt = 0; pulse = 1'b1; end
                   end
                default: nxt = 0;
            endcase
            s.age   = (nxt != s.phase) ? 0 : s.age + 1;
            s.phase = nxt;
            for (int x = 1; x <= 4; x++)
                st[x] = (s.phase == x) && (s.age > 0) && !(x == 4 && paused);
            exp = {3'(s.phase), st[1], st[2], st[3], st[4],
                   (s.phase == 2) && s.pass, (s.phase == 3) && s.pass,
                   (s.phase != 0) && (s.age > 0), pulse};
            m[k] = s;
        end
    endtask

    function automatic logic [10:0] obs_vec(input int k);
        if (k == 0)
            return {bus0.state, bus0.start_filling, bus0.start_washing, bus0.start_rinsing,
                    bus0.start_spinning, bus0.round2_washing, bus0.round2_rinsing,
                    bus0.soft_rst, bus0.wash_done};
        else
            return {bus1.state, bus1.start_filling, bus1.start_washing, bus1.start_rinsing,
                    bus1.start_spinning, bus1.round2_washing, bus1.round2_rinsing,
                    bus1.soft_rst, bus1.wash_done};
    endfunction

    initial begin
        logic [10:0] e0, e1;
        int pause_left;
        pause_left = 0;
        coin = 0; dw = 0; tp = 0; fd = 0; wd = 0; rd = 0; sd = 0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            rst_n = (cyc < 2) ? 1'b0 : ($urandom_range(0, 399) != 0);
            coin  = ($urandom_range(0, 5) == 0);
            dw    = $urandom_range(0, 1);
            fd    = ($urandom_range(0, 3) == 0);
            wd    = ($urandom_range(0, 3) == 0);
            rd    = ($urandom_range(0, 3) == 0);
            sd    = ($urandom_range(0, 2) == 0);
            if (pause_left > 0) pause_left--;
            else if ($urandom_range(0, 11) == 0) pause_left = $urandom_range(1, 12);
            tp = (pause_left > 0);
            @(posedge clk);
            model_step(0, 1'b1, 1'b1, e0);
            model_step(1, 1'b0, 1'b0, e1);
            #1;
            chk($sformatf("dut0_cyc%0d", cyc), 32'(obs_vec(0)), 32'(e0));
            chk($sformatf("dut1_cyc%0d", cyc), 32'(obs_vec(1)), 32'(e1));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
